des_key_scheduler: RTL and testbench

- Iterative DES key schedule that produces the sixteen 48-bit round subkeys from a 64-bit key, one per handshake.
- Runs forward for encryption (K1..K16, left rotations) or in the other direction for decryption (K16..K1, right rotations), so no subkey storage is needed.
- Sits between the key register and the round datapath. It contains its own PC-1 and PC-2 permutations.

---
 rtl/des_key_scheduler_if.sv | 24 ++
 rtl/des_key_scheduler.sv | 148 ++++++++++++++
 tb/tb_des_key_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/des_key_scheduler_if.sv
// Handshake bundle between the key register/round datapath and the DES key scheduler.
// The master issues start/key and consumes subkeys; the slave is the scheduler.
interface des_key_scheduler_if;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
    logic        key_err;

    modport master (
        output start, decrypt, key_in, subkey_ready,
        input  subkey, subkey_valid, round_idx, busy, done, key_err
    );

    modport slave (
        input  start, decrypt, key_in, subkey_ready,
        output subkey, subkey_valid, round_idx, busy, done, key_err
    );
endinterface

// File: rtl/des_key_scheduler.sv
// Iterative DES key schedule: one 48-bit subkey per handshake, forward (K1..K16)
// or reverse (K16..K1) by rotating C/D left or right, so no subkey storage is kept.
//
// state | meaning
// IDLE  | waiting for start; key parity optionally checked
// ROUND | subkey presented, advancing C/D on each accepted subkey
module des_key_scheduler #(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    des_key_scheduler_if.slave ks
);
    typedef enum logic {IDLE = 1'b0, ROUND = 1'b1} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // FIPS bit n maps to vector bit (width - n): bit 1 is the MSB
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction

    function automatic logic [1:0] shift_amt(input logic [4:0] rnd);
        return (rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic odd_parity_ok(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) ok &= ^k[8*b +: 8];
        return ok;
    endfunction

    state_t      state, state_nxt;
    logic [27:0] c_q, d_q;
    logic [3:0]  step_q;
    logic [3:0]  round_idx_q;
    logic        dec_q;
    logic        done_q;
    logic        key_err_q;
    logic        key_ok;
    logic        handshake;
    logic        last_step;
    logic [55:0] pc1_key;
    logic [1:0]  enc_shift;
    logic [1:0]  dec_shift;

    assign key_ok    = !PARITY_CHECK || odd_parity_ok(ks.key_in);
    assign handshake = (state == ROUND) && ks.subkey_ready;
    assign last_step = (step_q == 4'd15);
    assign pc1_key   = pc1(ks.key_in);
    assign enc_shift = shift_amt({1'b0, step_q} + 5'd2);
    // Right rotation undoes the left shift that produced the round just accepted
    assign dec_shift = shift_amt(5'd16 - {1'b0, step_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ks.start && key_ok) state_nxt = ROUND;
            ROUND:   if (handshake && last_step) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q         <= '0;
            d_q         <= '0;
            step_q      <= '0;
            round_idx_q <= '0;
            dec_q       <= 1'b0;
            done_q      <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            key_err_q <= 1'b0;
            if (state == IDLE && ks.start) begin
                if (!key_ok) begin
                    key_err_q <= 1'b1;
                end else begin
                    // C0/D0 equals C16/D16, so decrypt starts unrotated
                    c_q         <= ks.decrypt ? pc1_key[55:28] : rotl28(pc1_key[55:28], 2'd1);
                    d_q         <= ks.decrypt ? pc1_key[27:0]  : rotl28(pc1_key[27:0], 2'd1);
                    step_q      <= '0;
                    round_idx_q <= ks.decrypt ? 4'd15 : 4'd0;
                    dec_q       <= ks.decrypt;
                end
            end else if (handshake) begin
                if (last_step) begin
                    done_q <= 1'b1;
                end else begin
                    step_q <= step_q + 4'd1;
                    if (dec_q) begin
                        c_q         <= rotr28(c_q, dec_shift);
                        d_q         <= rotr28(d_q, dec_shift);
                        round_idx_q <= round_idx_q - 4'd1;
                    end else begin
                        c_q         <= rotl28(c_q, enc_shift);
                        d_q         <= rotl28(d_q, enc_shift);
                        round_idx_q <= round_idx_q + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        ks.subkey_valid = (state == ROUND);
        ks.busy         = (state == ROUND);
        ks.subkey       = pc2({c_q, d_q});
        ks.round_idx    = round_idx_q;
        ks.done         = done_q;
        ks.key_err      = key_err_q;
    end
endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: directed known-answer runs plus random
// keys, stalls and ignored mid-schedule inputs, checked against a cumulative-shift model.
module tb_des_key_scheduler;
    localparam logic [63:0] FIX_KEY = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] BAD_KEY = 64'h1334_5779_9BBC_DFF0;
    localparam logic [47:0] K1_REF  = 48'h1B02_EFFC_7072;
    localparam logic [47:0] K2_REF  = 48'h79AE_D9DB_C9E5;
    localparam logic [47:0] K16_REF = 48'hCB3D_8B0E_17F5;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [47:0] exp_k [16];
    logic [47:0] cap   [16];

    des_key_scheduler_if if0 ();
    des_key_scheduler_if if1 ();

    des_key_scheduler #(.PARITY_CHECK(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .ks(if0.slave));
    des_key_scheduler #(.PARITY_CHECK(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .ks(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Round r's C/D is C0/D0 rotated left by the running sum of shifts up to r
    task automatic model(input logic [63:0] key);
        logic [1:56] cd0;
        logic [1:56] cdr;
        int cum;
        for (int n = 1; n <= 56; n++) cd0[n] = key[64-PC1[n-1]];
        cum = 0;
        for (int r = 0; r < 16; r++) begin
            cum += SHIFTS[r];
            for (int j = 1; j <= 28; j++) begin
                cdr[j]    = cd0[((j - 1 + cum) % 28) + 1];
                cdr[28+j] = cd0[28 + ((j - 1 + cum) % 28) + 1];
            end
            for (int i = 1; i <= 48; i++) exp_k[r][48-i] = cdr[PC2[i-1]];
        end
    endtask

    // Starts at a negedge with dut0 idle (or in its done cycle); returns at the done negedge
    task automatic run_sched(input logic [63:0] key, input logic dec, input bit stalls);
        int got;
        int cyc;
        int stall;
        int idx;
        model(key);
        if0.start        = 1'b1;
        if0.decrypt      = dec;
        if0.key_in       = key;
        if0.subkey_ready = 1'b0;
        @(negedge clk);
        if0.start = 1'b0;
        chk("first_valid", 64'(if0.subkey_valid), 64'd1);
        chk("done_is_pulse", 64'(if0.done), 64'd0);
        got = 0;
        cyc = 0;
        stall = 0;
        while (got < 16 && cyc < 400) begin
            idx = dec ? 15 - got : got;
            chk("valid", 64'(if0.subkey_valid), 64'd1);
            chk("busy", 64'(if0.busy), 64'd1);
            chk("subkey", 64'(if0.subkey), 64'(exp_k[idx]));
            chk("round_idx", 64'(if0.round_idx), 64'(idx));
            if (!stalls) begin
                if0.subkey_ready = 1'b1;
            end else if (stall > 0) begin
                if0.subkey_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 3) == 0) begin
                if0.subkey_ready = 1'b0;
                stall = 2;
            end else begin
                if0.subkey_ready = 1'b1;
            end
            if0.decrypt = 1'($urandom);
            if0.key_in  = {$urandom, $urandom};
            if0.start   = ($urandom_range(0, 3) == 0);
            if (if0.subkey_ready) begin
                cap[got] = if0.subkey;
                got++;
            end
            cyc++;
            @(negedge clk);
        end
        if0.start        = 1'b0;
        if0.subkey_ready = 1'b0;
        chk("accept_count", 64'(got), 64'd16);
        if (!stalls) chk("cycle_count", 64'(cyc), 64'd16);
        chk("done_pulse", 64'(if0.done), 64'd1);
        chk("valid_end", 64'(if0.subkey_valid), 64'd0);
        chk("busy_end", 64'(if0.busy), 64'd0);
        chk("hold_subkey", 64'(if0.subkey), 64'(exp_k[dec ? 0 : 15]));
        chk("hold_idx", 64'(if0.round_idx), dec ? 64'd0 : 64'd15);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("done_drop", 64'(if0.done), 64'd0);
        chk("idle_valid", 64'(if0.subkey_valid), 64'd0);
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        if0.start = 1'b0; if0.decrypt = 1'b0; if0.key_in = '0; if0.subkey_ready = 1'b0;
        if1.start = 1'b0; if1.decrypt = 1'b0; if1.key_in = '0; if1.subkey_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_subkey", 64'(if0.subkey), 64'd0);
        chk("rst_valid", 64'(if0.subkey_valid), 64'd0);
        chk("rst_idx", 64'(if0.round_idx), 64'd0);
        chk("rst_busy", 64'(if0.busy), 64'd0);
        chk("rst_done", 64'(if0.done), 64'd0);
        chk("rst_key_err", 64'(if1.key_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sched(FIX_KEY, 1'b0, 1'b0);
        chk("enc_k1", 64'(cap[0]), 64'(K1_REF));
        chk("enc_k2", 64'(cap[1]), 64'(K2_REF));
        chk("enc_k16", 64'(cap[15]), 64'(K16_REF));
        idle_cycle();

        run_sched(FIX_KEY, 1'b1, 1'b0);
        chk("dec_first", 64'(cap[0]), 64'(K16_REF));
        chk("dec_last", 64'(cap[15]), 64'(K1_REF));
        idle_cycle();

        run_sched(FIX_KEY, 1'b0, 1'b1);
        chk("stall_k1", 64'(cap[0]), 64'(K1_REF));
        chk("stall_k16", 64'(cap[15]), 64'(K16_REF));
        idle_cycle();

        // Even-parity key is accepted when parity checking is off
        run_sched(BAD_KEY, 1'b0, 1'b0);
        // Chained runs: each new start lands in the previous done cycle
        for (int r = 0; r < 4; r++) run_sched({$urandom, $urandom}, 1'($urandom), 1'b1);
        idle_cycle();

        // Asynchronous reset after K5 is accepted
        model(FIX_KEY);
        if0.start = 1'b1; if0.decrypt = 1'b0; if0.key_in = FIX_KEY;
        @(negedge clk);
        if0.start = 1'b0;
        if0.subkey_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_idx", 64'(if0.round_idx), 64'd5);
        chk("pre_rst_k6", 64'(if0.subkey), 64'(exp_k[5]));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(if0.subkey_valid), 64'd0);
        chk("arst_subkey", 64'(if0.subkey), 64'd0);
        chk("arst_idx", 64'(if0.round_idx), 64'd0);
        chk("arst_busy", 64'(if0.busy), 64'd0);
        if0.subkey_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sched(FIX_KEY, 1'b0, 1'b0);
        chk("post_rst_k1", 64'(cap[0]), 64'(K1_REF));
        idle_cycle();

        // Parity checking instance
        if1.start = 1'b1; if1.decrypt = 1'b0; if1.key_in = BAD_KEY;
        @(negedge clk);
        if1.start = 1'b0;
        chk("key_err_pulse", 64'(if1.key_err), 64'd1);
        chk("bad_valid", 64'(if1.subkey_valid), 64'd0);
        chk("bad_busy", 64'(if1.busy), 64'd0);
        @(negedge clk);
        chk("key_err_drop", 64'(if1.key_err), 64'd0);
        chk("bad_still_idle", 64'(if1.subkey_valid), 64'd0);
        model(FIX_KEY);
        if1.start = 1'b1; if1.key_in = FIX_KEY;
        @(negedge clk);
        if1.start = 1'b0;
        if1.subkey_ready = 1'b1;
        chk("par_valid", 64'(if1.subkey_valid), 64'd1);
        chk("par_key_err", 64'(if1.key_err), 64'd0);
        n = 0;
        while (if1.subkey_valid && n < 20) begin
            chk("par_subkey", 64'(if1.subkey), 64'(exp_k[n]));
            n++;
            @(negedge clk);
        end
        if1.subkey_ready = 1'b0;
        chk("par_count", 64'(n), 64'd16);
        chk("par_done", 64'(if1.done), 64'd1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
